// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit.
// MULT/MULTU use a shift-add multiplier and DIV/DIVU use a restoring divider.
// Each operation takes 32 iteration cycles, and the result lands in HI/LO at FINISH.
// The unit also accepts direct MTHI/MTLO writes whenever it is not busy.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             mthiEnable,
    input  logic             mtloEnable,
    input  logic [WIDTH-1:0] writeData,
    output logic             busy,
    output logic             done,
    output logic             divByZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    logic               is_div;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [CNT_W-1:0]   count;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide: {partial remainder, remaining dividend / quotient bits}.
    logic [2*WIDTH-1:0] acc;

    logic               start_sign_a;
    logic               start_sign_b;
    logic [WIDTH-1:0]   start_a_abs;
    logic [WIDTH-1:0]   start_b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] acc_next;
    logic               div_zero;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    // Operand magnitudes at start (signed ops take |x|; unsigned ops use raw values)
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        start_sign_a = ~op[0] & operandA[WIDTH-1];
        start_sign_b = ~op[0] & operandB[WIDTH-1];
        start_a_abs  = start_sign_a ? -operandA : operandA;
        start_b_abs  = start_sign_b ? -operandB : operandB;
    end

    // One iteration step: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_trial = div_shift - {1'b0, b_mag};
        acc_next  = {mul_sum, acc[WIDTH-1:1]};
        if (is_div) begin
            if (div_trial[WIDTH])
                acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else
                acc_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
    end

    // Sign correction and the divide-by-zero override applied at FINISH
    always_comb begin
        div_zero = (b_mag == '0);
        product  = (sign_a ^ sign_b) ? -acc : acc;
        res_hi   = product[2*WIDTH-1:WIDTH];
        res_lo   = product[WIDTH-1:0];
        if (is_div) begin
            if (div_zero) begin
                res_lo = '1;
                res_hi = sign_a ? -a_mag : a_mag;
            end else begin
                res_lo = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                res_hi = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            end
        end
    end

    // Control FSM, the iteration datapath and the architectural HI/LO registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            divByZero <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            is_div    <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            a_mag     <= '0;
            b_mag     <= '0;
            count     <= '0;
            acc       <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            done <= 1'b0;
            if (!busy) begin
                if (mthiEnable) hi <= writeData;
                if (mtloEnable) lo <= writeData;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div <= op[1];
                        sign_a <= start_sign_a;
                        sign_b <= start_sign_b;
                        a_mag  <= start_a_abs;
                        b_mag  <= start_b_abs;
                        acc    <= op[1] ? {{WIDTH{1'b0}}, start_a_abs}
                                        : {{WIDTH{1'b0}}, start_b_abs};
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    if (count == LAST) state <= FINISH;
                    else               count <= count + CNT_W'(1);
                end
                FINISH: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    if (is_div) divByZero <= div_zero;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative HI/LO multiply/divide unit for the multi-cycle datapath.
- Sits directly downstream of the register file. operandA/operandB are driven from the register file's registered readData1/readData2.
- Computes MULT/MULTU/DIV/DIVU over 32 iteration cycles and holds the results in architectural HI/LO registers.
- Control FSM starts it and stalls on busy. Also supports direct MTHI/MTLO writes.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  request operation; sampled only in IDLE
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- operandA  input  WIDTH  multiplicand / dividend (rs)
- operandB  input  WIDTH  multiplier / divisor (rt)
- mthiEnable  input  1  write writeData into HI
- mtloEnable  input  1  write writeData into LO
- writeData  input  WIDTH  MTHI/MTLO data
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; hi/lo hold the new result
- divByZero  output  1  sticky flag for last divide; 1 if divisor was 0
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy=0, done=0, divByZero=0, hi=0, lo=0; counter and internal accumulators cleared.
- States: IDLE, CALC, FINISH.
- IDLE, start=1 at edge E0:
  - latch op and sign flags;
  - latch |operandA|, |operandB| (magnitudes for signed ops, raw values for unsigned);
  - counter=0, busy<=1, state->CALC.
- CALC, edges E1..E32: one iteration per edge.
  - Multiply: shift-add into 2*WIDTH product.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - At the edge where counter==WIDTH-1, state->FINISH; otherwise counter+1.
- FINISH, edge E33:
  - apply sign correction;
  - write hi/lo; done<=1, busy<=0; state->IDLE.
- Timing: busy high for cycles E0..E33 (33 cycles); done high for exactly one cycle after E33; done=0 all other cycles.
- Multiply result: {hi,lo} = full 2*WIDTH product.
  - Signed: product negated (two's complement, 64-bit) when operand signs differ.
- Divide result: lo=quotient, hi=remainder.
  - Signed quotient is negative when signs differ.
  - Remainder sign follows dividend.
  - Truncation toward zero.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (natural wrap); divByZero=0.
- Divide by zero:
  - Same 33-cycle latency.
  - lo=all ones, hi=dividend (original, unsigned view), divByZero=1.
  - divByZero is updated at FINISH of every divide and unchanged by multiplies.
- start while busy: ignored; no queuing.
- start in the cycle done is high: accepted (state is IDLE). Back-to-back throughput is one op per 34 cycles.
- MTHI/MTLO:
  - Honoured only when not busy; the write takes effect at that edge.
  - Ignored while busy, including the FINISH edge; computed result wins.
  - Both enables together write both registers.
  - Simultaneous with an accepted start: the write is applied, then overwritten at FINISH.
- Operands change after E0: no effect; operands are latched.
- Reset mid-operation: immediate abort to reset values; no done pulse; hi/lo return to 0.
- op=DIV/DIVU with start held high continuously: a new operation starts on every IDLE cycle.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF, start one cycle -> busy 33 cycles; done pulse at E33; hi=0xFFFFFFFE, lo=0x00000001.
- MULT -3 x 7, then back-to-back MULT 0x80000000 x 0x80000000 with start during done -> first hi=0xFFFFFFFF, lo=0xFFFFFFEB; second hi=0x40000000, lo=0x00000000; second done 34 cycles after first.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, divByZero=0.
- DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=0x00000064, divByZero=1. Subsequent MULTU 2x3 -> lo=6, hi=0, divByZero stays 1.
- MTHI 0x12345678 while idle -> hi=0x12345678 next edge. mtloEnable while busy -> lo unchanged until FINISH result. start pulsed mid-CALC -> ignored, single done.
- Assert rst=0 at E10 of a DIVU (asynchronous, between edges) -> busy, done, hi, lo drop to 0 immediately. After release, a new MULTU 5x5 gives lo=25 at E33.
